// File: rtl/crc5_pkg.sv
// crc5_pkg: shared CRC-5 constants, frame FSM states and the serial CRC update
package crc5_pkg;
    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
    localparam logic [7:0] SYNC_DEFAULT  = 8'b0000_0001;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, CRC} tx_state_t;

    function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic d);
        logic fb;
        fb = c[4] ^ d;
        return {c[3], c[2], c[1] ^ fb, c[0], fb};
    endfunction
endpackage

// File: rtl/crc5_frame_tx_if.sv
// crc5_frame_tx_if: payload valid/ready handshake into the framed transmitter
interface crc5_frame_tx_if #(parameter int DATA_W = 11);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master(output in_valid, in_data, input in_ready);
    modport slave(input in_valid, in_data, output in_ready);
endinterface

// File: rtl/crc5_lfsr.sv
// crc5_lfsr: serial CRC-5 register with init/step/hold, shared with the receivers
module crc5_lfsr
    import crc5_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       step,
    input  logic       d,
    output logic [4:0] c
);
    // init wins over step; otherwise the register holds
    always_ff @(posedge clk or posedge rst)
        if (rst) c <= CRC5_INIT;
        else if (init) c <= CRC5_INIT;
        else if (step) c <= crc5_next(c, d);
endmodule

// File: rtl/crc5_frame_tx.sv
// crc5_frame_tx: sync + payload + inverted CRC-5 serialiser with one-word holding register
// Optional bit stuffing after six ones in DATA/CRC: define CRC5_TX_STUFF_EN
module crc5_frame_tx
    import crc5_pkg::*;
#(
    parameter int                DATA_W   = 11,
    parameter int                SYNC_W   = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   abort,
    crc5_frame_tx_if.slave         bus,
    output logic                   tx_bit,
    output logic                   tx_active,
    output logic                   tx_last
);
    localparam int         SH_W     = SYNC_W - 1 + DATA_W;
    localparam logic [4:0] SYNC_END = 5'(SYNC_W);
    localparam logic [4:0] DATA_END = 5'(SYNC_W + DATA_W);
    localparam logic [4:0] LAST     = 5'(SYNC_W + DATA_W + 4);

    tx_state_t         state_q, state_d;
    logic [4:0]        cnt_q, cnt_d, n, idx, c;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full, bit_d, act_d, last_d, load, crc_init, crc_step;
`ifdef CRC5_TX_STUFF_EN
    logic [2:0]        ones_q, ones_d;
`endif

    assign bus.in_ready = ~hold_full;

    crc5_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .init(crc_init),
        .step(crc_step),
        .d   (sh_q[SH_W-1]),
        .c   (c)
    );

    // frame sequencing: cnt_q is the frame position of the bit currently on tx_bit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        bit_d    = tx_bit;
        act_d    = tx_active;
        last_d   = tx_last;
        load     = 1'b0;
        crc_init = 1'b0;
        crc_step = 1'b0;
        n        = cnt_q + 5'd1;
        idx      = LAST - n;
`ifdef CRC5_TX_STUFF_EN
        ones_d   = ones_q;
`endif
        if (abort) begin
            state_d  = IDLE;
            bit_d    = 1'b1;
            act_d    = 1'b0;
            last_d   = 1'b0;
            crc_init = 1'b1;
        end else if (en) begin
`ifdef CRC5_TX_STUFF_EN
            if (state_q inside {DATA, CRC} && ones_q == 3'd6) begin
                bit_d  = 1'b0;
                last_d = 1'b0;
            end else
`endif
            if (state_q == IDLE || cnt_q == LAST) begin
                if (hold_full) begin
                    load     = 1'b1;
                    crc_init = 1'b1;
                    state_d  = SYNC;
                    cnt_d    = 5'd0;
                    sh_d     = {SYNC_PAT[SYNC_W-2:0], hold_q};
                    bit_d    = SYNC_PAT[SYNC_W-1];
                    act_d    = 1'b1;
                    last_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    bit_d   = 1'b1;
                    act_d   = 1'b0;
                    last_d  = 1'b0;
                end
            end else begin
                cnt_d = n;
                if (n < DATA_END) begin
                    bit_d    = sh_q[SH_W-1];
                    sh_d     = sh_q << 1;
                    crc_step = n >= SYNC_END;
                    state_d  = n >= SYNC_END ? DATA : SYNC;
                end else begin
                    bit_d   = ~c[idx[2:0]];
                    state_d = CRC;
                    last_d  = n == LAST;
                end
            end
`ifdef CRC5_TX_STUFF_EN
            ones_d = bit_d ? (load ? 3'd1 : ones_q + 3'd1) : 3'd0;
`endif
        end
    end

    // frame registers advance on en; the holding register follows the handshake every cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            tx_bit    <= 1'b1;
            tx_active <= 1'b0;
            tx_last   <= 1'b0;
`ifdef CRC5_TX_STUFF_EN
            ones_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            tx_bit    <= bit_d;
            tx_active <= act_d;
            tx_last   <= last_d;
            hold_full <= (abort || load) ? 1'b0 : (bus.in_valid && !hold_full) ? 1'b1 : hold_full;
            hold_q    <= (bus.in_valid && !hold_full && !abort) ? bus.in_data : hold_q;
`ifdef CRC5_TX_STUFF_EN
            ones_q    <= ones_d;
`endif
        end
endmodule

// File: tb/tb_crc5_frame_tx.sv
// tb_crc5_frame_tx: scoreboard bench; frames predicted from a queue of accepted words
module tb_crc5_frame_tx;
    logic clk = 0, rst = 1, en = 0, abort = 0;
    logic tx_bit, tx_active, tx_last;
    int   n_vec = 0, n_err = 0, mode = 0, ecnt = 0, pos = 0;
    logic [2:0]  cur[$];
    logic [10:0] words[$];
    logic [4:0]  rx;
    logic [2:0]  prev = 3'b100;

    crc5_frame_tx_if #(.DATA_W(11)) bus();

    crc5_frame_tx dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .abort    (abort),
        .bus      (bus),
        .tx_bit   (tx_bit),
        .tx_active(tx_active),
        .tx_last  (tx_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ecnt++;
        en = mode == 0 ? 1'b1 : mode == 1 ? (ecnt % 3 == 0) : 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build(input logic [10:0] w);
        logic [4:0]  c = 5'h1f;
        logic [23:0] f;
        int          ones = 0;
        for (int i = 10; i >= 0; i--) c = {c[3:0], 1'b0} ^ ((c[4] ^ w[i]) ? 5'b00101 : 5'b0);
        f = {8'b0000_0001, w, ~c};
        for (int i = 23; i >= 0; i--) begin
            cur.push_back({1'b0, i == 0, f[i]});
            ones = f[i] ? ones + 1 : 0;
`ifdef CRC5_TX_STUFF_EN
            if (i < 16 && ones == 6) begin
                cur.push_back(3'b100);
                ones = 0;
            end
`endif
        end
    endfunction

    always @(posedge clk) begin
        logic s_en, s_ab, s_x;
        logic [10:0] s_d;
        int pend;
        logic [2:0] o, e;
        s_en = en;
        s_ab = abort;
        s_x  = bus.in_valid & bus.in_ready & ~abort;
        s_d  = bus.in_data;
        pend = words.size();
        #1;
        o = {tx_bit, tx_active, tx_last};
        if (rst) begin
            cur.delete();
            words.delete();
        end else begin
            if (s_ab) begin
                check("abort_out", o, 3'b100);
                cur.delete();
                words.delete();
            end else begin
                if (!s_en) check("hold_out", o, prev);
                else begin
                    if (cur.size() == 0 && pend > 0) begin
                        build(words.pop_front());
                        rx  = 5'h1f;
                        pos = 0;
                    end
                    if (cur.size() == 0) check("idle_out", o, 3'b100);
                    else begin
                        e = cur.pop_front();
                        check("frame_out", o, {e[0], 1'b1, e[1]});
                        if (!e[2]) begin
                            if (pos >= 8) rx = {rx[3:0], 1'b0} ^ ((rx[4] ^ tx_bit) ? 5'b00101 : 5'b0);
                            pos++;
                        end
                        if (e[1]) check("residual", rx, crc5_pkg::CRC5_RESIDUAL);
                    end
                end
                if (s_x) words.push_back(s_d);
            end
            check("in_ready", bus.in_ready, words.size() == 0);
        end
        prev = o;
    end

    task automatic send(input logic [10:0] w);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((cur.size() != 0 || words.size() != 0 || tx_active) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", cur.size() + words.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_left(input int left);
        int t = 0;
        while (cur.size() != left && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("wait_left", cur.size(), left);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_bit", tx_bit, 1);
        check("rst_active", tx_active, 0);
        check("rst_last", tx_last, 0);
        check("rst_ready", bus.in_ready, 1);
        rst = 0;
        send(11'h000);
        wait_idle();
        send(11'h000);
        send(11'h7ff);
        wait_idle();
        mode = 1;
        send(11'h5a3);
        wait_idle();
        mode = 0;
        send(11'h000);
        send(11'h2b6);
        wait_left(11);
        abort = 1;
        @(negedge clk);
        abort = 0;
        send(11'h000);
        wait_idle();
        repeat (30) begin
            mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(11'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                abort = 1;
                @(negedge clk);
                abort = 0;
            end
        end
        wait_idle();
        mode = 0;
        send(11'h5a3);
        wait_left(15);
        #3 rst = 1;
        #1;
        check("rst_mid_out", {tx_bit, tx_active, tx_last}, 3'b100);
        check("rst_mid_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 0;
        send(11'h0f0);
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
